// File: rtl/mips_trace_monitor.sv
// Trace monitor: captures {PC, instr, ctrl} while the core runs, stops on halt or timeout, then drains oldest-first.
// Control-word storage is optional via the MIPS_TRACE_CTRL_EN macro (undefined: rd_ctrl reads 0).
module mips_trace_monitor #(
    parameter int WIDTH    = 16,
    parameter int CTRL_W   = 11,
    parameter int DEPTH    = 16,
    parameter int HALT_CYC = 4,
    parameter int TIMEOUT  = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   en,
    input  logic [WIDTH-1:0]       pc_in,
    input  logic [WIDTH-1:0]       instr_in,
    input  logic [CTRL_W-1:0]      ctrl_in,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_pc,
    output logic [WIDTH-1:0]       rd_instr,
    output logic [CTRL_W-1:0]      rd_ctrl,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            cycle_cnt,
    output logic                   halted,
    output logic                   timeout,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(HALT_CYC) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2, DONE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      cyc_q, cyc_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic [WIDTH-1:0] last_pc_q, last_pc_d;
    logic             halted_q, halted_d, timeout_q, timeout_d, overflow_q, overflow_d;
    logic             capture_s, pop_s, pc_eq_s, halt_hit_s, to_hit_s, rd_valid_s;
    logic [CTRL_W-1:0] ctrl_rd_s;

    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [WIDTH-1:0] instr_mem_q [DEPTH];

    assign rd_valid_s = (count_q != '0) && ((state_q == HALT) || (state_q == DONE));
    assign capture_s  = en && ((state_q == IDLE) || (state_q == RUN)) && !clear;
    assign pop_s      = rd_valid_s && rd_ready && !clear;
    // The very first sample of a run has no predecessor, so repeats only count in RUN.
    assign pc_eq_s    = (state_q == RUN) && (pc_in == last_pc_q);
    assign halt_hit_s = pc_eq_s && (rep_q == RW'(HALT_CYC - 1));
    assign to_hit_s   = (state_q == RUN) && (cyc_q == 16'(TIMEOUT - 1));

    // Next-state logic for the FSM, buffer pointers, counters and sticky flags.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cyc_d      = cyc_q;
        rep_d      = rep_q;
        last_pc_d  = last_pc_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;
        if (clear) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            cyc_d      = '0;
            rep_d      = '0;
            last_pc_d  = '0;
            halted_d   = 1'b0;
            timeout_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (capture_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q == CW'(DEPTH)) begin
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
                cyc_d     = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
                rep_d     = pc_eq_s ? rep_q + RW'(1) : '0;
                last_pc_d = pc_in;
            end else if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_d = RUN;
                    end else if (halt_hit_s) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else if (to_hit_s) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                HALT:    state_d = HALT;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            rep_q      <= '0;
            last_pc_q  <= '0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cyc_q      <= cyc_d;
            rep_q      <= rep_d;
            last_pc_q  <= last_pc_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    // Trace storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            pc_mem_q[wr_ptr_q]    <= pc_in;
            instr_mem_q[wr_ptr_q] <= instr_in;
        end
    end

`ifdef MIPS_TRACE_CTRL_EN
    logic [CTRL_W-1:0] ctrl_mem_q [DEPTH];

    // Control-word lane shares the PC/instruction write pointer.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            ctrl_mem_q[wr_ptr_q] <= ctrl_in;
        end
    end
    assign ctrl_rd_s = ctrl_mem_q[rd_ptr_q];
`else
    logic unused_ctrl_s;
    assign unused_ctrl_s = ^ctrl_in;
    assign ctrl_rd_s     = '0;
`endif

    // Read port is forced to zero whenever no entry is offered.
    always_comb begin
        if (rd_valid_s) begin
            rd_pc    = pc_mem_q[rd_ptr_q];
            rd_instr = instr_mem_q[rd_ptr_q];
            rd_ctrl  = ctrl_rd_s;
        end else begin
            rd_pc    = '0;
            rd_instr = '0;
            rd_ctrl  = '0;
        end
    end

    assign rd_valid  = rd_valid_s;
    assign count     = count_q;
    assign cycle_cnt = cyc_q;
    assign halted    = halted_q;
    assign timeout   = timeout_q;
    assign overflow  = overflow_q;
endmodule
